// File: rtl/pipe_elastic_reg_if.sv
// Handshake bundle for the elastic pipeline register.
// Carries both the upstream (in_*) and downstream (out_*) sides of one stage.
interface pipe_elastic_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // Environment view: offers upstream beats and consumes downstream beats.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Register view: accepts upstream beats and presents downstream beats.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register with a two-entry skid buffer.
// in_ready is decoded purely from the state register, so stalls move back
// one stage per cycle without a combinational ready chain. A flush discards
// held entries (and any beat accepted in that cycle) and counts them in a
// saturating debug counter.
module pipe_elastic_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_elastic_reg_if.slave    bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     flush_cnt
);

  // Encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam int               SUM_W   = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_main;
  logic [WIDTH-1:0]   r_skid;
  logic [CNT_W-1:0]   r_flush_cnt;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_main_nxt;
  logic [WIDTH-1:0]   w_skid_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               w_in_fire;
  logic               w_out_fire;
  logic [1:0]         w_discard;
  logic [SUM_W-1:0]   w_cnt_sum;
  logic [CNT_W-1:0]   w_cnt_sat;

  assign bus.in_ready  = (r_state != S_FULL);
  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.out_data  = r_main;
  assign occupancy     = r_state;
  assign flush_cnt     = r_flush_cnt;

  assign w_in_fire  = bus.in_valid  & bus.in_ready;
  assign w_out_fire = bus.out_valid & bus.out_ready;

  // Entries lost by a flush: held ones not leaving now, plus one arriving now.
  // Range is 0..2 because a beat can only arrive when at most one is held.
  assign w_discard = occupancy - {1'b0, w_out_fire} + {1'b0, w_in_fire};
  assign w_cnt_sum = SUM_W'(r_flush_cnt) + SUM_W'(w_discard);
  assign w_cnt_sat = (w_cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_cnt_sum[CNT_W-1:0];

  // Next-state, next-data and next-count decode; flush overrides the handshake.
  always_comb begin
    // NOTE: every target gets a hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    w_cnt_nxt   = r_flush_cnt;

    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = RESET_VAL;
      w_skid_nxt  = RESET_VAL;
      w_cnt_nxt   = w_cnt_sat;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = bus.in_data;
            w_state_nxt = S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = bus.in_data;
          end else if (w_in_fire) begin
            // Downstream stalled after we had already advertised ready:
            // park the extra beat in the skid register.
            w_skid_nxt  = bus.in_data;
            w_state_nxt = S_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = S_BUSY;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // State, data and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_flush_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Self-checking bench for pipe_elastic_reg. Two instances share one stimulus
// stream: one with the default 8-bit flush counter and one with a 2-bit
// counter to reach saturation. A queue model tracks held beats and an
// unsaturated discard count.
module tb_pipe_elastic_reg;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RVAL  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             flush;
  logic             drv_valid;
  logic [WIDTH-1:0] drv_data;
  logic             drv_ready;

  logic [1:0] occ_a, occ_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  pipe_elastic_reg_if #(.WIDTH(WIDTH)) bus_a ();
  pipe_elastic_reg_if #(.WIDTH(WIDTH)) bus_b ();

  assign bus_a.in_valid  = drv_valid;
  assign bus_a.in_data   = drv_data;
  assign bus_a.out_ready = drv_ready;
  assign bus_b.in_valid  = drv_valid;
  assign bus_b.in_data   = drv_data;
  assign bus_b.out_ready = drv_ready;

  pipe_elastic_reg #(.WIDTH(WIDTH), .RESET_VAL(RVAL), .CNT_W(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus_a),
    .occupancy (occ_a),
    .flush_cnt (cnt_a)
  );

  pipe_elastic_reg #(.WIDTH(WIDTH), .RESET_VAL(RVAL), .CNT_W(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus_b),
    .occupancy (occ_b),
    .flush_cnt (cnt_b)
  );

  // Reference model: beats currently held, in acceptance order, and the
  // total number of discarded beats since the last reset.
  logic [WIDTH-1:0] m_q[$];
  int               m_cnt;
  bit               chk_en;

  int n_checks;
  int n_errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  // Apply one cycle's behaviour from the rules: at most two beats held, a
  // beat is taken only when fewer than two are held, flush empties the
  // buffer and counts what it threw away.
  function automatic void model_step();
    bit in_f;
    bit out_f;
    in_f  = drv_valid && (m_q.size() < 2);
    out_f = drv_ready && (m_q.size() > 0);
    if (rst) begin
      m_q.delete();
      m_cnt = 0;
    end else if (flush) begin
      m_cnt = m_cnt + m_q.size() - int'(out_f) + int'(in_f);
      m_q.delete();
    end else begin
      if (out_f) void'(m_q.pop_front());
      if (in_f) m_q.push_back(drv_data);
    end
  endfunction

  // Drive inputs for one cycle (called just after a falling edge), advance
  // the model at the rising edge and return at the next falling edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic rdy,
                       input logic fl, input logic r);
    drv_valid = v;
    drv_data  = d;
    drv_ready = rdy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Compare process: every falling edge, DUT outputs versus the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("occupancy",  {62'd0, occ_a}, 64'(m_q.size()));
        check("occ_b",      {62'd0, occ_b}, 64'(m_q.size()));
        check("out_valid",  {63'd0, bus_a.out_valid}, {63'd0, m_q.size() != 0});
        check("in_ready",   {63'd0, bus_a.in_ready},  {63'd0, m_q.size() < 2});
        if (m_q.size() != 0) begin
          check("out_data",   {32'd0, bus_a.out_data}, {32'd0, m_q[0]});
          check("out_data_b", {32'd0, bus_b.out_data}, {32'd0, m_q[0]});
        end
        check("flush_cnt",   {56'd0, cnt_a}, 64'(sat(m_cnt, 255)));
        check("flush_cnt_b", {62'd0, cnt_b}, 64'(sat(m_cnt, 3)));
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    chk_en    = 1'b0;
    m_cnt     = 0;
    drv_valid = 1'b0;
    drv_data  = '0;
    drv_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    @(negedge clk);

    // Reset state.
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("rst_out_valid", {63'd0, bus_a.out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, bus_a.in_ready},  64'd1);
    check("rst_occ",       {62'd0, occ_a},           64'd0);
    check("rst_out_data",  {32'd0, bus_a.out_data},  {32'd0, RVAL});
    check("rst_flush_cnt", {56'd0, cnt_a},           64'd0);

    // Streaming at one beat per cycle.
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    check("stream0", {32'd0, bus_a.out_data}, 64'h100);
    check("stream0_occ", {62'd0, occ_a}, 64'd1);
    cycle(1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
    check("stream1", {32'd0, bus_a.out_data}, 64'h104);
    cycle(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    check("stream2", {32'd0, bus_a.out_data}, 64'h108);
    check("stream2_rdy", {63'd0, bus_a.in_ready}, 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("drain_occ", {62'd0, occ_a}, 64'd0);

    // Stall into the skid register, then release.
    cycle(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
    check("skid_occ",   {62'd0, occ_a},           64'd2);
    check("skid_rdy",   {63'd0, bus_a.in_ready},  64'd0);
    check("skid_head",  {32'd0, bus_a.out_data},  64'h200);
    cycle(1'b1, 32'h208, 1'b1, 1'b0, 1'b0);
    check("skid_next",  {32'd0, bus_a.out_data},  64'h204);
    check("skid_occ1",  {62'd0, occ_a},           64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("skid_empty", {62'd0, occ_a},           64'd0);

    // Flush while FULL.
    cycle(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("flfull_occ",  {62'd0, occ_a},          64'd0);
    check("flfull_data", {32'd0, bus_a.out_data}, {32'd0, RVAL});
    check("flfull_cnt",  {56'd0, cnt_a},          64'd2);

    // Flush with a beat leaving and a beat arriving in the same cycle.
    cycle(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    check("flsim_head", {32'd0, bus_a.out_data}, 64'h400);
    cycle(1'b1, 32'h404, 1'b1, 1'b1, 1'b0);
    check("flsim_occ",  {62'd0, occ_a}, 64'd0);
    check("flsim_cnt",  {56'd0, cnt_a}, 64'd3);

    // Flush held over several cycles with beats offered: each is discarded.
    cycle(1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h504, 1'b0, 1'b1, 1'b0);
    check("flhold_rdy", {63'd0, bus_a.in_ready}, 64'd1);
    check("flhold_cnt", {56'd0, cnt_a}, 64'd5);

    // Saturation of the 2-bit counter over four FULL flushes.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("sat_rst", {62'd0, cnt_b}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'h600 + 32'(k), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h700 + 32'(k), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("sat_b", {62'd0, cnt_b}, (k == 0) ? 64'd2 : 64'd3);
      check("sat_a", {56'd0, cnt_a}, 64'(2 * (k + 1)));
    end

    // Randomised traffic against the model.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 3) != 0,
            $urandom,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0,
            $urandom_range(0, 1999) == 0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_elastic_reg.md
# pipe_elastic_reg

Parametrised elastic pipeline register: the next-generation inter-stage register for the MIPS pipeline. It replaces the plain enable/clear register with a valid/ready handshake and a two-entry skid buffer. Stalls therefore propagate one stage per cycle without a combinational ready path, and no data is lost or duplicated. Flush discards in-flight entries and counts them for pipeline debug.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (PC or bundled stage fields)
- RESET_VAL, 0, value loaded into both data registers on reset and flush
- CNT_W, 8, width of the flushed-entry counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all held entries (branch/jump redirect)
- in_valid  input  1  upstream beat present
- in_data  input  WIDTH  upstream payload
- in_ready  output  1  block accepts a beat this cycle
- out_valid  output  1  downstream beat present
- out_data  output  WIDTH  downstream payload
- out_ready  input  1  downstream accepts a beat this cycle
- occupancy  output  2  held entries: 0, 1 or 2
- flush_cnt  output  CNT_W  saturating count of discarded valid entries

## Operation
- Storage:
  - main register, which drives out_data
  - skid register, used only when downstream stalls after a beat was accepted
- States:
  - EMPTY: occupancy 0
  - BUSY: occupancy 1, held in main
  - FULL: occupancy 2, main plus skid
- Derived signals:
  - in_ready = (state != FULL), decoded from state register only; no dependence on out_ready
  - out_valid = (state != EMPTY)
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready
- Transitions, with rst and flush low:
  - EMPTY, in_fire: main <= in_data, go to BUSY
  - BUSY, in_fire & out_fire: main <= in_data, stay in BUSY
  - BUSY, in_fire & !out_fire: skid <= in_data, go to FULL
  - BUSY, !in_fire & out_fire: go to EMPTY; main keeps its stale value
  - FULL, out_fire: main <= skid, go to BUSY; in_fire is impossible in FULL
  - Any other case: hold state and data
- Flush:
  - Priority: rst > flush > handshake.
  - On a flush cycle, next state is EMPTY and main and skid load RESET_VAL.
  - A beat that fires out in the flush cycle is delivered normally.
  - A beat that fires in during the flush cycle is discarded.
  - Discarded count d = occupancy − out_fire + in_fire, with range 0..2 (max 2, since in_fire implies occupancy ≤ 1).
  - flush_cnt <= min(flush_cnt + d, 2^CNT_W − 1), saturating with no wrap.
- Reset: state EMPTY, main and skid = RESET_VAL, flush_cnt = 0.
- out_data is meaningful only while out_valid = 1.

## Timing
- Reset values after the first rising edge with rst = 1:
  - out_valid = 0, in_ready = 1, occupancy = 0
  - out_data = RESET_VAL, flush_cnt = 0
- Latency: a beat accepted at edge N with the block EMPTY is on out_data, with out_valid = 1, after edge N.
- Throughput: 1 beat/cycle sustained while out_ready = 1.
- Backpressure: after out_ready drops, at most one further beat is accepted (into skid). in_ready falls on the following edge.
- Ordering: beats leave strictly in acceptance order; no beat is duplicated or dropped except by flush.
- rst asserted mid-transfer: all held entries are lost. flush_cnt is not incremented, because it clears.
- flush and rst held for multiple cycles: the block stays EMPTY with in_ready = 1. Beats offered during flush are discarded and counted.

## Test plan
- Reset then stream: rst 1 cycle; in_valid = 1 with data 0x100, 0x104, 0x108 on consecutive cycles, out_ready = 1 → out_data is 0x100, 0x104, 0x108 on the next three cycles, occupancy stays 1, in_ready stays 1.
- Stall/skid: BUSY holding 0x200; drop out_ready while sending 0x204 → FULL, in_ready = 0, occupancy = 2. Raise out_ready → outputs 0x200 then 0x204, with no loss.
- Flush when FULL: FULL with 0x300/0x304, out_ready = 0, flush = 1 → next cycle EMPTY, out_data = RESET_VAL, flush_cnt += 2.
- Flush with simultaneous fires: BUSY, out_ready = 1, in_valid = 1 (0x404), flush = 1 → held beat delivered, 0x404 discarded, flush_cnt += 1, state EMPTY.
- Saturation: CNT_W = 2; run four FULL flushes → flush_cnt reads 2, then 3, 3, 3.
- Random: random in_valid/out_ready/flush for 10k cycles against a reference queue model → identical output order, occupancy within 0..2, flush_cnt equal to the model's count.
